// File: rtl/cam_pkg.sv
// Shared camera/frame-buffer definitions: capture FSM states, frame geometry
// and RGB565 field layout used by the capture, VGA and filter stages.
package cam_pkg;

  localparam int FRAME_WIDTH  = 320;
  localparam int FRAME_HEIGHT = 240;
  localparam int FRAME_PIXELS = FRAME_WIDTH * FRAME_HEIGHT;
  localparam int PIXEL_W      = 16;

  localparam int R_MSB = 15;
  localparam int R_LSB = 11;
  localparam int G_MSB = 10;
  localparam int G_LSB = 5;
  localparam int B_MSB = 4;
  localparam int B_LSB = 0;

  typedef enum logic [1:0] {
    ST_IDLE       = 2'd0,
    ST_WAIT_VSYNC = 2'd1,
    ST_WAIT_START = 2'd2,
    ST_CAPTURE    = 2'd3
  } cam_state_t;

  typedef enum logic {
    PH_HI = 1'b0,
    PH_LO = 1'b1
  } byte_phase_t;

  // Camera sends the RGB565 word high byte first, so the fields fall straight through.
  function automatic logic [PIXEL_W-1:0] rgb565_pack(input logic [7:0] hi, input logic [7:0] lo);
    logic [15:0]        w;
    logic [PIXEL_W-1:0] p;
    w = {hi, lo};
    p = '0;
    p[R_MSB:R_LSB] = w[R_MSB:R_LSB];
    p[G_MSB:G_LSB] = w[G_MSB:G_LSB];
    p[B_MSB:B_LSB] = w[B_MSB:B_LSB];
    return p;
  endfunction

endpackage

// File: rtl/cam_frame_capture_if.sv
// Camera byte stream in, frame-buffer write port out. The capture stage uses
// the master view; the frame buffer / camera model side uses the slave view.
interface cam_frame_capture_if
  import cam_pkg::*;
#(
  parameter int ADDR_W = 17
);

  logic               cam_vsync;
  logic               cam_href;
  logic               cam_byte_valid;
  logic [7:0]         cam_data;
  logic               wren;
  logic [ADDR_W-1:0]  wraddress;
  logic [PIXEL_W-1:0] wrdata;

  modport master (
    input  cam_vsync, cam_href, cam_byte_valid, cam_data,
    output wren, wraddress, wrdata
  );

  modport slave (
    output cam_vsync, cam_href, cam_byte_valid, cam_data,
    input  wren, wraddress, wrdata
  );

endinterface

// File: rtl/cam_byte_pair.sv
// Pairs camera bytes into RGB565 pixels within a line, counts completed pixels
// and flags lines with the wrong pixel count or an odd number of bytes.
module cam_byte_pair
  import cam_pkg::*;
#(
  parameter int SRC_WIDTH = 640,
  parameter int SXW       = $clog2(SRC_WIDTH) + 1
) (
  input  logic               clk_25MHz,
  input  logic               reset,
  input  logic               clear,
  input  logic               active,
  input  logic               cam_href,
  input  logic               cam_byte_valid,
  input  logic [7:0]         cam_data,
  output logic               line_start,
  output logic               line_end,
  output logic               pix_strobe,
  output logic [PIXEL_W-1:0] pix_data,
  output logic [SXW-1:0]     pix_x,
  output logic               line_err
);

  logic        href_d;
  byte_phase_t phase, phase_eff;
  logic [7:0]  hi;
  logic [SXW-1:0] sx, sx_eff;
  logic        restart, take;

  // A byte arriving on the href rise cycle is already the high byte of pixel 0.
  always_comb begin
    line_start = cam_href & ~href_d;
    line_end   = ~cam_href & href_d;
    restart    = clear | line_start;
    phase_eff  = restart ? PH_HI : phase;
    sx_eff     = restart ? '0 : sx;
    take       = active & cam_href & cam_byte_valid;
    pix_strobe = take & (phase_eff == PH_LO);
    pix_data   = rgb565_pack(hi, cam_data);
    pix_x      = sx_eff;
    line_err   = active & line_end & ((sx != SXW'(SRC_WIDTH)) | (phase == PH_LO));
  end

  always_ff @(posedge clk_25MHz) begin
    if (reset) begin
      href_d <= 1'b0;
      phase  <= PH_HI;
      hi     <= '0;
      sx     <= '0;
    end else begin
      href_d <= cam_href;
      phase  <= phase_eff;
      sx     <= sx_eff;
      if (take) begin
        if (phase_eff == PH_HI) begin
          hi    <= cam_data;
          phase <= PH_LO;
        end else begin
          phase <= PH_HI;
          if (sx_eff != '1) sx <= sx_eff + SXW'(1);
        end
      end
    end
  end

endmodule

// File: rtl/cam_frame_capture.sv
// Camera capture stage: frame-aligned start/stop, 2:1 decimation in X and Y,
// linear frame-buffer addressing and torn-frame detection.
module cam_frame_capture
  import cam_pkg::*;
#(
  parameter int SRC_WIDTH  = 640,
  parameter int SRC_HEIGHT = 480,
  parameter int DST_WIDTH  = FRAME_WIDTH,
  parameter int DST_HEIGHT = FRAME_HEIGHT,
  parameter int ADDR_W     = $clog2(FRAME_PIXELS)
) (
  input  logic                clk_25MHz,
  input  logic                reset,
  input  logic                capture_en,
  cam_frame_capture_if.master bus,
  output logic                capturing,
  output logic                frame_done,
  output logic                frame_err
);

  localparam int SXW  = $clog2(SRC_WIDTH) + 1;
  localparam int SYW  = $clog2(SRC_HEIGHT) + 1;
  localparam int CNTW = ADDR_W + 1;

  cam_state_t state, state_d;

  logic vsync_d, vsync_rise, vsync_fall;
  logic frame_end, start, active;
  logic line_start, line_end, pix_strobe, line_err;
  logic [PIXEL_W-1:0] pix_data;
  logic [SXW-1:0]     pix_x;

  logic [SYW-1:0]     sy;
  logic [ADDR_W-1:0]  line_base, addr_cnt;
  logic [CNTW-1:0]    write_cnt;
  logic               err_pend;
  logic               kept, overflow, frame_good;

  logic               wren_q;
  logic [ADDR_W-1:0]  wraddress_q;
  logic [PIXEL_W-1:0] wrdata_q;

  cam_byte_pair #(
    .SRC_WIDTH (SRC_WIDTH),
    .SXW       (SXW)
  ) u_byte_pair (
    .clk_25MHz      (clk_25MHz),
    .reset          (reset),
    .clear          (start),
    .active         (active),
    .cam_href       (bus.cam_href),
    .cam_byte_valid (bus.cam_byte_valid),
    .cam_data       (bus.cam_data),
    .line_start     (line_start),
    .line_end       (line_end),
    .pix_strobe     (pix_strobe),
    .pix_data       (pix_data),
    .pix_x          (pix_x),
    .line_err       (line_err)
  );

  always_comb begin
    vsync_rise = bus.cam_vsync & ~vsync_d;
    vsync_fall = ~bus.cam_vsync & vsync_d;
    frame_end  = (state == ST_CAPTURE) & vsync_rise;
    start      = (state == ST_WAIT_START) & vsync_fall;
    active     = (state == ST_CAPTURE) & ~vsync_rise;
    kept       = pix_strobe & ~pix_x[0] & ~sy[0] &
                 (pix_x < SXW'(SRC_WIDTH)) & (sy < SYW'(SRC_HEIGHT));
    overflow   = pix_strobe & ((pix_x >= SXW'(SRC_WIDTH)) | (sy >= SYW'(SRC_HEIGHT)));
    frame_good = (write_cnt == CNTW'(DST_WIDTH * DST_HEIGHT)) & ~err_pend &
                 (sy == SYW'(SRC_HEIGHT));
  end

  always_comb begin
    state_d = state;
    unique case (state)
      ST_IDLE:       if (capture_en) state_d = ST_WAIT_VSYNC;
      ST_WAIT_VSYNC: if (vsync_rise) state_d = ST_WAIT_START;
      ST_WAIT_START: if (vsync_fall) state_d = ST_CAPTURE;
      ST_CAPTURE:    if (vsync_rise) state_d = capture_en ? ST_WAIT_START : ST_IDLE;
      default:       state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_25MHz) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_d;
  end

  // addr_cnt is re-based from line_base on every href rise, so a short or long
  // line can never shift the addresses of the lines after it.
  always_ff @(posedge clk_25MHz) begin
    if (reset) begin
      vsync_d     <= 1'b0;
      sy          <= '0;
      line_base   <= '0;
      addr_cnt    <= '0;
      write_cnt   <= '0;
      err_pend    <= 1'b0;
      wren_q      <= 1'b0;
      wraddress_q <= '0;
      wrdata_q    <= '0;
      frame_done  <= 1'b0;
      frame_err   <= 1'b0;
    end else begin
      vsync_d    <= bus.cam_vsync;
      wren_q     <= 1'b0;
      frame_done <= 1'b0;
      if (start) begin
        sy        <= '0;
        line_base <= '0;
        addr_cnt  <= '0;
        write_cnt <= '0;
        err_pend  <= 1'b0;
      end else if (active) begin
        if (line_start) addr_cnt <= line_base;
        if (kept) begin
          wren_q      <= 1'b1;
          wraddress_q <= addr_cnt;
          wrdata_q    <= pix_data;
          addr_cnt    <= addr_cnt + ADDR_W'(1);
          write_cnt   <= write_cnt + CNTW'(1);
        end
        if (overflow | line_err) err_pend <= 1'b1;
        if (line_end) begin
          if (sy != '1) sy <= sy + SYW'(1);
          if (sy[0] && (sy < SYW'(SRC_HEIGHT))) line_base <= line_base + ADDR_W'(DST_WIDTH);
        end
      end
      if (frame_end) begin
        if (frame_good) begin
          frame_done <= 1'b1;
          frame_err  <= 1'b0;
        end else begin
          frame_err  <= 1'b1;
        end
      end
    end
  end

  assign capturing     = (state == ST_CAPTURE);
  assign bus.wren      = wren_q;
  assign bus.wraddress = wraddress_q;
  assign bus.wrdata    = wrdata_q;

endmodule

// File: tb/tb_cam_frame_capture.sv
// Directed frame-level bench for cam_frame_capture on a reduced 16x12 sensor
// (8x6 frame buffer): a table of frame scenarios plus a mid-line reset sequence.
module tb_cam_frame_capture;
  import cam_pkg::*;

  localparam int SW = 16;
  localparam int SH = 12;
  localparam int DW = 8;
  localparam int DH = 6;
  localparam int AW = 17;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [15:0]   data;
  } wr_t;

  typedef struct {
    int en_start;
    int en_line;
    int en_after;
    int lines;
    int bad_line;
    int bad_len;
    int expect_cap;
    int exp_done;
    int exp_err;
  } vec_t;

  logic clk = 1'b0;
  logic reset;
  logic capture_en;
  logic capturing, frame_done, frame_err;

  cam_frame_capture_if #(.ADDR_W(AW)) bus ();

  cam_frame_capture #(
    .SRC_WIDTH  (SW),
    .SRC_HEIGHT (SH),
    .DST_WIDTH  (DW),
    .DST_HEIGHT (DH),
    .ADDR_W     (AW)
  ) dut (
    .clk_25MHz  (clk),
    .reset      (reset),
    .capture_en (capture_en),
    .bus        (bus),
    .capturing  (capturing),
    .frame_done (frame_done),
    .frame_err  (frame_err)
  );

  always #20 clk = ~clk;

  wr_t  got_q[$];
  wr_t  exp_q[$];
  int   done_cnt = 0;
  int   checks = 0;
  int   errors = 0;
  int   last_base;
  vec_t vecs[10];

  always @(negedge clk) begin
    if (bus.wren === 1'b1) got_q.push_back('{bus.wraddress, bus.wrdata});
    if (frame_done === 1'b1) done_cnt++;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic blank();
    bus.cam_vsync = 1'b1;
    repeat (6) step();
    bus.cam_vsync = 1'b0;
    repeat (6) step();
  endtask

  task automatic drive_line(input int y, input int len, input int collect);
    logic [7:0] yb, xb;
    yb = 8'(y);
    bus.cam_href = 1'b1;
    for (int x = 0; x < len; x++) begin
      xb = 8'(x);
      bus.cam_byte_valid = 1'b1;
      bus.cam_data = yb;
      step();
      bus.cam_data = xb;
      step();
      if (collect != 0 && x % 2 == 0 && y % 2 == 0 && x < SW && y < SH)
        exp_q.push_back('{AW'((y / 2) * DW + x / 2), {yb, xb}});
    end
    bus.cam_byte_valid = 1'b0;
    bus.cam_href = 1'b0;
    repeat (4) step();
  endtask

  task automatic run_frame(input int idx, input vec_t v);
    int db, n;
    last_base = got_q.size();
    db = done_cnt;
    exp_q.delete();
    capture_en = 1'(v.en_start);
    for (int y = 0; y < v.lines; y++) begin
      if (y == v.en_line) capture_en = 1'(v.en_after);
      drive_line(y, (y == v.bad_line) ? v.bad_len : SW, v.expect_cap);
      if (y == 6) check($sformatf("f%0d_capturing", idx), 32'(capturing), 32'(v.expect_cap));
    end
    blank();
    n = got_q.size() - last_base;
    check($sformatf("f%0d_nwrites", idx), 32'(n), 32'(exp_q.size()));
    for (int i = 0; i < n && i < exp_q.size(); i++) begin
      check($sformatf("f%0d_addr[%0d]", idx, i), 32'(got_q[last_base+i].addr), 32'(exp_q[i].addr));
      check($sformatf("f%0d_data[%0d]", idx, i), 32'(got_q[last_base+i].data), 32'(exp_q[i].data));
    end
    check($sformatf("f%0d_done_pulses", idx), 32'(done_cnt - db), 32'(v.exp_done));
    check($sformatf("f%0d_frame_err", idx), 32'(frame_err), 32'(v.exp_err));
  endtask

  initial begin
    int   n, db, maxa;
    logic found;
    vec_t clean;

    //             en  enL enA lines badL badLen cap done err
    vecs[0] = '{0,  3,  1,  12,  -1,  0,    0,  0,   0};  // enable mid-frame: armed only
    vecs[1] = '{1, -1,  1,  12,  -1,  0,    1,  1,   0};  // first clean frame
    vecs[2] = '{1, -1,  1,  12,   4, 10,    1,  0,   1};  // short line
    vecs[3] = '{1, -1,  1,  12,  -1,  0,    1,  1,   0};  // recovers, clears err
    vecs[4] = '{1, -1,  1,  12,   4, 20,    1,  0,   1};  // long line
    vecs[5] = '{1,  7,  0,  12,  -1,  0,    1,  1,   0};  // enable dropped mid-frame
    vecs[6] = '{0, -1,  0,  12,  -1,  0,    0,  0,   0};  // idle frame
    vecs[7] = '{1, -1,  1,  12,  -1,  0,    0,  0,   0};  // re-armed, waiting
    vecs[8] = '{1, -1,  1,  11,  -1,  0,    1,  0,   1};  // too few lines
    vecs[9] = '{1, -1,  1,  13,  -1,  0,    1,  0,   1};  // too many lines
    clean   = '{1, -1,  1,  12,  -1,  0,    1,  1,   0};

    reset = 1'b1;
    capture_en = 1'b0;
    bus.cam_vsync = 1'b0;
    bus.cam_href = 1'b0;
    bus.cam_byte_valid = 1'b0;
    bus.cam_data = '0;
    repeat (3) step();
    check("rst_wren", 32'(bus.wren), 0);
    check("rst_wraddress", 32'(bus.wraddress), 0);
    check("rst_wrdata", 32'(bus.wrdata), 0);
    check("rst_capturing", 32'(capturing), 0);
    check("rst_frame_done", 32'(frame_done), 0);
    check("rst_frame_err", 32'(frame_err), 0);
    reset = 1'b0;
    step();
    blank();

    for (int i = 0; i < 10; i++) begin
      run_frame(i, vecs[i]);
      if (i == 1) begin
        n = got_q.size();
        check("f1_first_addr", (n > last_base) ? 32'(got_q[last_base].addr) : 32'hFFFF_FFFF, 0);
        found = 1'b0;
        for (int k = last_base; k < n; k++) begin
          if (got_q[k].addr == AW'(DW + 1)) begin
            found = 1'b1;
            check("f1_addr9_data", 32'(got_q[k].data), 32'h0202);
          end
        end
        check("f1_addr9_present", 32'(found), 1);
      end
      if (i == 2) begin
        n = got_q.size();
        check("f2_line6_addr", (n > last_base + 21) ? 32'(got_q[last_base+21].addr) : 32'hFFFF_FFFF, 24);
      end
      if (i == 4) begin
        maxa = 0;
        for (int k = last_base; k < got_q.size(); k++)
          if (int'(got_q[k].addr) > maxa) maxa = int'(got_q[k].addr);
        check("f4_max_addr", 32'(maxa), DW * DH - 1);
      end
      if (i == 5) check("f5_idle_after", 32'(capturing), 0);
    end

    // Mid-line reset during an armed capture, then re-arm.
    drive_line(0, SW, 0);
    drive_line(1, SW, 0);
    bus.cam_href = 1'b1;
    for (int x = 0; x < 5; x++) begin
      bus.cam_byte_valid = 1'b1;
      bus.cam_data = 8'd2;
      step();
      bus.cam_data = 8'(x);
      step();
    end
    bus.cam_byte_valid = 1'b0;
    step();
    check("pre_rst_wraddress", 32'(bus.wraddress), 10);
    check("pre_rst_wrdata", 32'(bus.wrdata), 32'h0204);
    check("pre_rst_frame_err", 32'(frame_err), 1);
    check("pre_rst_capturing", 32'(capturing), 1);
    reset = 1'b1;
    bus.cam_byte_valid = 1'b1;
    bus.cam_data = 8'h55;
    step();
    check("mid_rst_wren", 32'(bus.wren), 0);
    check("mid_rst_wraddress", 32'(bus.wraddress), 0);
    check("mid_rst_wrdata", 32'(bus.wrdata), 0);
    check("mid_rst_capturing", 32'(capturing), 0);
    check("mid_rst_frame_done", 32'(frame_done), 0);
    check("mid_rst_frame_err", 32'(frame_err), 0);
    reset = 1'b0;
    bus.cam_byte_valid = 1'b0;
    bus.cam_href = 1'b0;
    repeat (4) step();
    db = done_cnt;
    blank();
    check("rst_no_done", 32'(done_cnt - db), 0);
    run_frame(10, clean);
    n = got_q.size();
    check("rearm_first_addr", (n > last_base) ? 32'(got_q[last_base].addr) : 32'hFFFF_FFFF, 0);
    check("rearm_second_data", (n > last_base + 1) ? 32'(got_q[last_base+1].data) : 32'hFFFF_FFFF, 32'h0002);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
